// File: rtl/param_pkg.sv
// Shared definitions for the parameter ping-pong bank: packet geometry, FSM encoding,
// and byte offsets of the parameter map as seen through rd_data.
package param_pkg;

    localparam int NUM_BYTES = 55;
    localparam int IDX_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } pb_state_e;

    // Parameter map offsets for consumers of the read port
    localparam logic [IDX_W-1:0] OFS_MODE     = 6'd0;
    localparam logic [IDX_W-1:0] OFS_VTX_BASE = 6'd1;
    localparam logic [IDX_W-1:0] OFS_TEX_BASE = 6'd25;
    localparam logic [IDX_W-1:0] OFS_COLOR    = 6'd49;
    localparam logic [IDX_W-1:0] OFS_CSUM     = 6'd54;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/param_bank_2x.sv
// Two NUM_BYTES x 8 register banks with a single write port and a combinational
// read mux; out-of-range read addresses return zero.
module param_bank_2x
    import param_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] bank0_r [NUM_BYTES];
    logic [7:0] bank1_r [NUM_BYTES];

    // Byte write into the selected bank; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we && (wr_addr < IDX_W'(NUM_BYTES))) begin
            if (wr_bank) begin
                bank1_r[wr_addr] <= wr_data;
            end else begin
                bank0_r[wr_addr] <= wr_data;
            end
        end
    end

    // Read mux over the requested bank
    always_comb begin
        rd_data = 8'h00;
        if (rd_addr < IDX_W'(NUM_BYTES)) begin
            rd_data = rd_bank ? bank1_r[rd_addr] : bank0_r[rd_addr];
        end else begin
            rd_data = 8'h00;
        end
    end

endmodule

// File: rtl/param_bank_ctrl.sv
// Packet sequencer for the ping-pong parameter bank: loads the inactive bank, swaps on frame_start.
// Optional build macro PARAM_CHECKSUM_EN adds an XOR checksum on the last packet byte.
module param_bank_ctrl
    import param_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update_reg,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       read_data,
    input  logic             pc_ready,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             bank_sel,
    output logic             commit,
    output logic             frame_valid,
    output logic             pending,
    output logic             err_seq,
    output logic             err_timeout,
    output logic             err_csum,
    output logic [7:0]       drop_cnt
);

    pb_state_e        state_r, state_nxt_s;
    logic [IDX_W-1:0] exp_r, exp_nxt_s;
    logic [TO_W-1:0]  to_r, to_nxt_s;
    logic             bank_sel_r, commit_r, frame_valid_r, pending_r;
    logic             err_seq_r, err_timeout_r, err_csum_r;
    logic [7:0]       drop_cnt_r;
    logic             we_s, wr_bank_s, commit_s, err_seq_s, err_to_s, err_csum_s, drop_s;
    logic             start_s, in_seq_s, csum_bad_s;

    assign start_s  = update_reg && (idx == IDX_W'(0));
    assign in_seq_s = update_reg && (idx == exp_r) && (exp_r < IDX_W'(NUM_BYTES));

`ifdef PARAM_CHECKSUM_EN
    logic [7:0] csum_r;

    // Running XOR over the packet; a byte 0 write restarts it, so a good packet folds to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_r <= 8'h00;
        end else if (we_s) begin
            csum_r <= (idx == IDX_W'(0)) ? read_data : (csum_r ^ read_data);
        end
    end

    assign csum_bad_s = (csum_r != 8'h00);
`else
    assign csum_bad_s = 1'b0;
`endif

    // Next-state, bank write and strobe decode
    always_comb begin
        state_nxt_s = state_r;
        exp_nxt_s   = exp_r;
        to_nxt_s    = to_r;
        we_s        = 1'b0;
        wr_bank_s   = ~bank_sel_r;
        commit_s    = 1'b0;
        err_seq_s   = 1'b0;
        err_to_s    = 1'b0;
        err_csum_s  = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    we_s        = 1'b1;
                    exp_nxt_s   = IDX_W'(1);
                    to_nxt_s    = TO_W'(0);
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_seq_s) begin
                    we_s      = 1'b1;
                    exp_nxt_s = exp_r + IDX_W'(1);
                    to_nxt_s  = TO_W'(0);
                end else if (update_reg) begin
                    err_seq_s = 1'b1;
                    drop_s    = 1'b1;
                    to_nxt_s  = TO_W'(0);
                    // A stray byte 0 is taken as the start of a fresh packet
                    if (start_s) begin
                        we_s        = 1'b1;
                        exp_nxt_s   = IDX_W'(1);
                        state_nxt_s = ST_LOAD;
                    end else begin
                        exp_nxt_s   = IDX_W'(0);
                        state_nxt_s = ST_IDLE;
                    end
                end else if (pc_ready) begin
                    exp_nxt_s = IDX_W'(0);
                    to_nxt_s  = TO_W'(0);
                    if (exp_r != IDX_W'(NUM_BYTES)) begin
                        err_seq_s   = 1'b1;
                        drop_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (csum_bad_s) begin
                        err_csum_s  = 1'b1;
                        drop_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PENDING;
                    end
                end else if (to_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_to_s    = 1'b1;
                    drop_s      = 1'b1;
                    exp_nxt_s   = IDX_W'(0);
                    to_nxt_s    = TO_W'(0);
                    state_nxt_s = ST_IDLE;
                end else begin
                    to_nxt_s = to_r + TO_W'(1);
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    commit_s = 1'b1;
                    // Byte 0 arriving with the swap lands in the bank being retired
                    if (start_s) begin
                        we_s        = 1'b1;
                        wr_bank_s   = bank_sel_r;
                        exp_nxt_s   = IDX_W'(1);
                        to_nxt_s    = TO_W'(0);
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (start_s) begin
                    drop_s      = 1'b1;
                    we_s        = 1'b1;
                    exp_nxt_s   = IDX_W'(1);
                    to_nxt_s    = TO_W'(0);
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                exp_nxt_s   = IDX_W'(0);
                to_nxt_s    = TO_W'(0);
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            exp_r         <= IDX_W'(0);
            to_r          <= TO_W'(0);
            bank_sel_r    <= 1'b0;
            commit_r      <= 1'b0;
            frame_valid_r <= 1'b0;
            pending_r     <= 1'b0;
            err_seq_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            err_csum_r    <= 1'b0;
            drop_cnt_r    <= 8'h00;
        end else begin
            state_r       <= state_nxt_s;
            exp_r         <= exp_nxt_s;
            to_r          <= to_nxt_s;
            bank_sel_r    <= bank_sel_r ^ commit_s;
            commit_r      <= commit_s;
            frame_valid_r <= frame_valid_r | commit_s;
            pending_r     <= (state_nxt_s == ST_PENDING);
            err_seq_r     <= err_seq_s;
            err_timeout_r <= err_to_s;
            err_csum_r    <= err_csum_s;
            drop_cnt_r    <= drop_s ? sat_inc8(drop_cnt_r) : drop_cnt_r;
        end
    end

    param_bank_2x u_bank (
        .clk     (clk),
        .we      (we_s),
        .wr_bank (wr_bank_s),
        .wr_addr (idx),
        .wr_data (read_data),
        .rd_bank (bank_sel_r),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    assign bank_sel    = bank_sel_r;
    assign commit      = commit_r;
    assign frame_valid = frame_valid_r;
    assign pending     = pending_r;
    assign err_seq     = err_seq_r;
    assign err_timeout = err_timeout_r;
    assign err_csum    = err_csum_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_param_bank_ctrl.sv
// Scoreboard bench for param_bank_ctrl: expected commit/error events are queued as
// stimulus is driven and matched against DUT strobes; a bank model checks rd_data.
module tb_param_bank_ctrl;
    import param_pkg::*;

    localparam int TO_CYC = 100;
    localparam logic [3:0] EV_COMMIT = 4'b0001;
    localparam logic [3:0] EV_SEQ    = 4'b0010;
    localparam logic [3:0] EV_TO     = 4'b0100;
    localparam logic [3:0] EV_CSUM   = 4'b1000;

    logic             clk = 1'b0;
    logic             reset, update_reg, pc_ready, frame_start;
    logic [IDX_W-1:0] idx, rd_idx;
    logic [7:0]       read_data, rd_data, drop_cnt;
    logic             bank_sel, commit, frame_valid, pending;
    logic             err_seq, err_timeout, err_csum;

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] drop;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_drop = 0;
    logic [7:0] mdl [2][NUM_BYTES];
    logic       mdl_bank = 1'b0;
    logic [7:0] pkt [NUM_BYTES];

    always #5 clk = ~clk;

    param_bank_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(16)) dut (
        .clk(clk), .reset(reset), .update_reg(update_reg), .idx(idx),
        .read_data(read_data), .pc_ready(pc_ready), .frame_start(frame_start),
        .rd_idx(rd_idx), .rd_data(rd_data), .bank_sel(bank_sel), .commit(commit),
        .frame_valid(frame_valid), .pending(pending), .err_seq(err_seq),
        .err_timeout(err_timeout), .err_csum(err_csum), .drop_cnt(drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input logic [3:0] k);
        ev_t e;
        if (k != EV_COMMIT) exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
        e.kind = k;
        e.drop = exp_drop[7:0];
        exp_q.push_back(e);
    endtask

    // Match every DUT strobe against the head of the expected-event queue
    always @(negedge clk) begin : monitor
        logic [3:0] obs_k;
        ev_t        e;
        obs_k = {err_csum, err_timeout, err_seq, commit};
        if (!reset && obs_k != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_event", {28'd0, obs_k}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("event_kind", {28'd0, obs_k}, {28'd0, e.kind});
                check_val("event_drop", {24'd0, drop_cnt}, {24'd0, e.drop});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int i, input logic [7:0] d, input bit wr);
        update_reg = 1'b1;
        idx        = i[IDX_W-1:0];
        read_data  = d;
        if (wr) mdl[~mdl_bank][i] = d;
        tick();
        update_reg = 1'b0;
    endtask

    task automatic build_pkt(input logic [7:0] seed);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
            pkt[k] = 8'(k) ^ seed;
            if (k < NUM_BYTES - 1) x = x ^ pkt[k];
        end
`ifdef PARAM_CHECKSUM_EN
        pkt[NUM_BYTES-1] = x;
`endif
    endtask

    task automatic send_pkt_from(input int first);
        for (int k = first; k < NUM_BYTES; k++) send_byte(k, pkt[k], 1'b1);
    endtask

    task automatic pulse_pc();
        pc_ready = 1'b1;
        tick();
        pc_ready = 1'b0;
    endtask

    task automatic do_commit();
        expect_ev(EV_COMMIT);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        mdl_bank = ~mdl_bank;
        check_val("commit_pulse", {31'd0, commit}, 32'd1);
        check_val("bank_sel", {31'd0, bank_sel}, {31'd0, mdl_bank});
        check_val("frame_valid", {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic check_rd(input int i);
        rd_idx = i[IDX_W-1:0];
        #1;
        check_val("rd_data", {24'd0, rd_data},
                  {24'd0, (i < NUM_BYTES) ? mdl[mdl_bank][i] : 8'h00});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        reset = 1'b1; update_reg = 1'b0; pc_ready = 1'b0; frame_start = 1'b0;
        idx = '0; rd_idx = '0; read_data = 8'h00;
        tick(); tick(); tick();
        check_val("rst_outputs", {24'd0, bank_sel, commit, frame_valid, pending,
                  err_seq, err_timeout, err_csum, 1'b0}, 32'd0);
        check_val("rst_drop", {24'd0, drop_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Full in-order packet, held pending for 10 cycles, then swapped
        build_pkt(8'h00);
        send_pkt_from(0);
        pulse_pc();
        check_val("pending_set", {31'd0, pending}, 32'd1);
        repeat (10) tick();
        check_val("pending_hold", {31'd0, pending}, 32'd1);
        check_val("bank_before", {31'd0, bank_sel}, 32'd0);
        do_commit();
        tick();
        check_val("pending_clr", {31'd0, pending}, 32'd0);
        check_rd(20);
        check_rd(0);
        check_rd(54);
        check_rd(60);

        // Out-of-order index drops the packet, idle ignores stray bytes, next packet commits
        build_pkt(8'h5A);
        for (int k = 0; k < 10; k++) send_byte(k, pkt[k], 1'b1);
        expect_ev(EV_SEQ);
        send_byte(11, pkt[11], 1'b0);
        check_val("seq_drop", {24'd0, drop_cnt}, 32'd1);
        send_byte(5, 8'hEE, 1'b0);
        tick();
        check_val("idle_no_pend", {31'd0, pending}, 32'd0);
        send_pkt_from(0);
        pulse_pc();
        do_commit();
        check_rd(0);
        check_rd(33);

        // Pending packet commits while the next packet's byte 0 arrives in the same cycle
        build_pkt(8'hA5);
        send_pkt_from(0);
        pulse_pc();
        check_val("pending_b", {31'd0, pending}, 32'd1);
        build_pkt(8'h3C);
        expect_ev(EV_COMMIT);
        update_reg = 1'b1; idx = '0; read_data = pkt[0]; frame_start = 1'b1;
        mdl[mdl_bank][0] = pkt[0];
        tick();
        update_reg = 1'b0; frame_start = 1'b0;
        mdl_bank = ~mdl_bank;
        check_val("coinc_bank", {31'd0, bank_sel}, {31'd0, mdl_bank});
        check_val("coinc_drop", {24'd0, drop_cnt}, exp_drop);
        check_rd(7);
        send_pkt_from(1);
        pulse_pc();
        check_val("pending_c", {31'd0, pending}, 32'd1);
        do_commit();
        check_rd(0);
        check_rd(40);

        // Inter-byte timeout measured from the last strobe
        build_pkt(8'h11);
        for (int k = 0; k < 5; k++) send_byte(k, pkt[k], 1'b1);
        expect_ev(EV_TO);
        cyc = -1;
        for (int c = 1; c <= TO_CYC + 20; c++) begin
            tick();
            if (err_timeout) begin
                cyc = c;
                break;
            end
        end
        check_val("timeout_latency", cyc, TO_CYC);
        tick();
        check_val("to_no_pend", {31'd0, pending}, 32'd0);
        check_val("to_bank", {31'd0, bank_sel}, {31'd0, mdl_bank});

        // Last byte breaks the XOR checksum
        for (int k = 0; k < NUM_BYTES; k++) pkt[k] = 8'h01;
        send_pkt_from(0);
`ifdef PARAM_CHECKSUM_EN
        expect_ev(EV_CSUM);
        pulse_pc();
        check_val("csum_err", {31'd0, err_csum}, 32'd1);
        tick();
        check_val("csum_no_pend", {31'd0, pending}, 32'd0);
        check_val("csum_bank", {31'd0, bank_sel}, {31'd0, mdl_bank});
`else
        pulse_pc();
        check_val("nocsum_err", {31'd0, err_csum}, 32'd0);
        check_val("nocsum_pend", {31'd0, pending}, 32'd1);
        do_commit();
        check_rd(54);
`endif
        pkt[NUM_BYTES-1] = 8'h00;
        send_pkt_from(0);
        pulse_pc();
        check_val("csum_ok_pend", {31'd0, pending}, 32'd1);
        do_commit();
        check_rd(54);

        // Reset while pending loses the packet; a later frame_start does nothing
        build_pkt(8'h77);
        send_pkt_from(0);
        pulse_pc();
        check_val("pending_r", {31'd0, pending}, 32'd1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_drop = 0;
        mdl_bank = 1'b0;
        check_val("rst2_outputs", {24'd0, bank_sel, commit, frame_valid, pending,
                  err_seq, err_timeout, err_csum, 1'b0}, 32'd0);
        check_val("rst2_drop", {24'd0, drop_cnt}, 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("rst2_no_commit", {31'd0, commit}, 32'd0);
        check_val("rst2_bank", {31'd0, bank_sel}, 32'd0);
        check_rd(3);

        // drop_cnt saturates at 255
        for (int n = 0; n < 260; n++) begin
            send_byte(0, 8'(n), 1'b1);
            expect_ev(EV_SEQ);
            send_byte(2, 8'h00, 1'b0);
        end
        tick();
        check_val("drop_sat", {24'd0, drop_cnt}, 32'd255);

        tick(); tick();
        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_bank_ctrl.md
Name: param_bank_ctrl

Overview:
Sequences the 55-byte parameter packets from the UART packet loader (read_data/idx/update_reg/pc_ready) into a ping-pong register bank.
- Writes each incoming byte into the inactive bank and checks packet sequencing.
- Holds a complete packet pending, then swaps banks only at a frame boundary, so the raster/vertex pipeline never sees a half-updated parameter set.
- Provides an indexed read port into the active bank, plus error and status strobes.

Parameters:
NUM_BYTES, 55, bytes per packet (valid idx 0..NUM_BYTES-1)
IDX_W, 6, width of idx and rd_idx
TIMEOUT_CYCLES, 65535, max clk cycles between bytes inside a packet before abort
TO_W, 16, timeout counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
update_reg  in  1  1-cycle byte strobe from loader
idx  in  IDX_W  byte index qualifying update_reg
read_data  in  8  byte value qualifying update_reg
pc_ready  in  1  1-cycle end-of-packet pulse, arrives 1 cycle after the idx=NUM_BYTES-1 strobe
frame_start  in  1  1-cycle frame-boundary pulse from video timing
rd_idx  in  IDX_W  read address into active bank
rd_data  out  8  active-bank byte, combinational; 0 when rd_idx>=NUM_BYTES
bank_sel  out  1  active bank (0/1); write bank is ~bank_sel
commit  out  1  1-cycle pulse on bank swap
frame_valid  out  1  sticky, set on first commit
pending  out  1  complete packet waiting for frame_start
err_seq  out  1  1-cycle pulse, out-of-order idx or early pc_ready
err_timeout  out  1  1-cycle pulse, inter-byte timeout
err_csum  out  1  1-cycle pulse, checksum mismatch (0 when feature off)
drop_cnt  out  8  saturating count of discarded packets

Behaviour:
- Reset: bank_sel=0, commit=0, frame_valid=0, pending=0, all err_*=0, drop_cnt=0, state=IDLE, expected index=0, timeout counter=0. Bank contents are not reset.
- Reset mid-packet or mid-PENDING: the packet is lost and no commit occurs.

IDLE:
- update_reg with idx==0: write byte to write bank[0], expected=1, go LOAD.
- update_reg with idx!=0: ignored silently; this resyncs on the next packet.
- pc_ready: ignored.

LOAD:
- update_reg with idx==expected: write byte, expected+1, clear timeout counter.
- update_reg with idx!=expected: pulse err_seq, drop_cnt+1, go IDLE. If that idx==0, it is treated as a new packet start in the same cycle: write byte 0, stay LOAD, expected=1.
- pc_ready with expected==NUM_BYTES: go PENDING, pending=1.
- pc_ready with expected!=NUM_BYTES: err_seq, drop_cnt+1, go IDLE.
- Timeout counter reaches TIMEOUT_CYCLES-1 with no strobe: err_timeout, drop_cnt+1, go IDLE.

PENDING:
- frame_start: bank_sel toggles, commit=1 for one cycle, frame_valid=1, pending=0, go IDLE.
- update_reg idx==0 without frame_start: pending packet discarded (drop_cnt+1), byte written to write bank, go LOAD.
- frame_start and update_reg idx==0 in the same cycle: commit wins. Byte 0 goes to the new write bank (the old active bank), go LOAD.

General rules:
- frame_start outside PENDING: no effect.
- drop_cnt saturates at 255.
- The active bank is never written.
- rd_data is valid combinationally in the same cycle for both banks, including the cycle of commit (new bank_sel visible the cycle after).
- Latency: last byte to commit = 1 cycle (pc_ready) plus wait for frame_start; minimum 2 cycles after the last update_reg.

Optional Feature:
PARAM_CHECKSUM_EN
- Defined: byte NUM_BYTES-1 must equal the XOR of bytes 0..NUM_BYTES-2, accumulated on the fly during LOAD. On a valid pc_ready with a mismatch: err_csum pulse, drop_cnt+1, go IDLE with no PENDING. The checksum byte is still stored and readable.
- Undefined: no accumulator, err_csum tied 0, last byte is plain data.

Decomposition:
- Shared package param_pkg: NUM_BYTES, IDX_W, state encoding (IDLE/LOAD/PENDING), and named byte offsets of the parameter map used by consumers of rd_data.
- One sub-module, param_bank_2x: two NUM_BYTES×8 register arrays, a write port (we, bank, addr, data) and the combinational read mux.
- FSM, timeout counter and checksum stay in the top.

Test Plan:
- 55 in-order strobes (byte k=k), pc_ready, then frame_start 10 cycles later -> pending=1 until frame_start; commit pulse; bank_sel=1; frame_valid=1; rd_idx=20 -> rd_data=20.
- Strobes idx 0..9, then idx 11 -> err_seq pulse; drop_cnt=1; state IDLE; later full packet commits normally.
- Packet complete and pending, then second packet's idx 0 arrives together with frame_start -> first packet commits (bank_sel flips); second loads into other bank; drop_cnt unchanged.
- Strobes idx 0..4 then silence for TIMEOUT_CYCLES -> err_timeout at exactly TIMEOUT_CYCLES after last strobe; drop_cnt+1; no commit.
- With PARAM_CHECKSUM_EN: bytes 0..53 = 0x01 and byte 54 = 0x01 (wrong; correct is 0x00) -> err_csum; no pending; bank_sel unchanged. With byte 54 = 0x00 -> commit occurs.
- Assert reset while PENDING -> all outputs return to reset values; a following frame_start produces no commit.
